mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported instruction/data memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). It sits between those two requesters and the memory model in the pipeline top. It enforces one outstanding memory transaction at a time, with data-side priority and a bounded-starvation guarantee for fetch, and routes each response back to the requester that issued it.

## Interface
Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width; byte-enable width is DWIDTH/8
- MAX_STARVE, 4, consecutive data wins allowed while fetch waits; legal range ≥1

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_req_i  in  1  fetch read request; held until f_gnt_o
- f_addr_i  in  AWIDTH  fetch address
- f_gnt_o  out  1  one-cycle pulse: fetch request accepted
- f_rvalid_o  out  1  one-cycle pulse: f_rdata_o valid
- f_rdata_o  out  DWIDTH  instruction word
- d_req_i  in  1  data request; held until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  AWIDTH  data address
- d_wdata_i  in  DWIDTH  store data
- d_be_i  in  DWIDTH/8  store byte enables
- d_gnt_o  out  1  one-cycle pulse: data request accepted
- d_rvalid_o  out  1  one-cycle pulse: load data valid or store complete
- d_rdata_o  out  DWIDTH  load data; value don't-care for stores
- mem_req_o  out  1  request to memory
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/AWIDTH/DWIDTH/DWIDTH/8  registered request payload
- mem_ready_i  in  1  memory accepts request when mem_req_o && mem_ready_i
- mem_rvalid_i  in  1  memory response/ack, one cycle
- mem_rdata_i  in  DWIDTH  memory read data
- busy_o  out  1  state ≠ IDLE
- err_o  out  1  sticky protocol error

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any request is present, arbitrate, capture the winner's payload into mem_* registers, record the owner (F/D), and go to ISSUE. Fetch stores: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
- Arbitration: data wins unless starve_cnt == MAX_STARVE while f_req_i=1, in which case fetch wins. A lone requester always wins.
- starve_cnt: increments when data wins while f_req_i=1; clears when fetch wins or when f_req_i=0 at arbitration; saturates at MAX_STARVE.
- ISSUE: mem_req_o=1. The owner's gnt_o pulses in the first ISSUE cycle only. The state stays in ISSUE until mem_ready_i, then goes to WAIT with mem_req_o deasserted.
- WAIT: on mem_rvalid_i, register mem_rdata_i into the owner's rdata_o and pulse the owner's rvalid_o in the next cycle. Go to IDLE. The rdata_o registers hold their value until the next response to the same owner.
- A store also completes through mem_rvalid_i, which gives d_rvalid_o.
- mem_rvalid_i in ISSUE sets err_o and is otherwise ignored. mem_rvalid_i in IDLE is ignored and does not set err_o.
- Payload inputs are not sampled after capture. A requester may change its payload in the cycle after gnt_o.

## Timing
- Reset (async assert): state=IDLE. All outputs are 0, including the rdata registers, starve_cnt and err_o. Deassertion is used synchronously.
- Reset mid-transaction aborts the transaction. No gnt_o or rvalid_o is produced for it, and a late mem_rvalid_i arriving in IDLE is dropped.
- With a request present in IDLE at cycle 0: gnt_o and mem_req_o are high in cycle 1.
  - If mem_ready_i=1 in cycle 1, the state is WAIT in cycle 2.
  - If mem_rvalid_i=1 in cycle 2+k, rvalid_o=1 in cycle 3+k and the state is IDLE in cycle 3+k.
- IDLE in the rvalid cycle may arbitrate again. Minimum spacing is 3 cycles per transaction.
- rvalid_o and a new gnt_o are never high in the same cycle.
- Requests that arrive simultaneously in IDLE are resolved by the arbitration rule. The loser keeps its request asserted and is served next.

## Test plan
- Single fetch, addr 0x0100, mem_ready immediate, response after k=2 with data 0xDEADBEEF: f_gnt_o@1, f_rvalid_o@5 with f_rdata_o=0xDEADBEEF; d_* outputs stay 0.
- Store 0x12345678 to 0x2000 with be=4'b0011: mem_we_o=1 and the payload matches at the ISSUE handshake; d_rvalid_o pulses one cycle after mem_rvalid_i; f_rvalid_o stays 0.
- f_req_i and d_req_i held high continuously, MAX_STARVE=4: grant order is D,D,D,D,F,D,D,D,D,F; starve_cnt clears after each F grant.
- mem_ready_i held low for 5 cycles in ISSUE: mem_req_o and the payload stay stable, gnt_o pulses exactly once, and WAIT is entered in the cycle after ready.
- rst_n asserted during WAIT, then mem_rvalid_i arrives after release: all outputs are 0, no rvalid_o pulse, err_o=0.
- mem_rvalid_i pulsed during ISSUE: err_o=1 and stays sticky until reset; the transaction still completes normally on the later legitimate response.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between instruction fetch and data access.
// One outstanding transaction; data has priority, fetch starvation is bounded.
module mem_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                f_req_i,
    input  logic [AWIDTH-1:0]   f_addr_i,
    output logic                f_gnt_o,
    output logic                f_rvalid_o,
    output logic [DWIDTH-1:0]   f_rdata_o,

    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [AWIDTH-1:0]   d_addr_i,
    input  logic [DWIDTH-1:0]   d_wdata_i,
    input  logic [DWIDTH/8-1:0] d_be_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DWIDTH-1:0]   d_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [AWIDTH-1:0]   mem_addr_o,
    output logic [DWIDTH-1:0]   mem_wdata_o,
    output logic [DWIDTH/8-1:0] mem_be_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DWIDTH-1:0]   mem_rdata_i,

    output logic                busy_o,
    output logic                err_o
);

    // state  | meaning
    // IDLE   | no transaction; arbitrate and capture winner's payload
    // ISSUE  | mem_req_o high until the memory accepts it
    // WAIT   | accepted, waiting for the one-cycle memory response

    localparam int BWIDTH = DWIDTH / 8;
    localparam int SWIDTH = (MAX_STARVE < 2) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [SWIDTH-1:0] STARVE_MAX = SWIDTH'(MAX_STARVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                owner_data_q;
    logic [SWIDTH-1:0]   starve_q;
    logic [SWIDTH-1:0]   starve_d;

    logic                capture;
    logic                fetch_win;
    logic                resp_take;
    logic                err_set;

    logic                f_gnt_q;
    logic                d_gnt_q;
    logic                f_rvalid_q;
    logic                d_rvalid_q;
    logic [DWIDTH-1:0]   f_rdata_q;
    logic [DWIDTH-1:0]   d_rdata_q;

    logic                mem_we_q;
    logic [AWIDTH-1:0]   mem_addr_q;
    logic [DWIDTH-1:0]   mem_wdata_q;
    logic [BWIDTH-1:0]   mem_be_q;
    logic                err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        capture   = 1'b0;
        fetch_win = 1'b0;
        resp_take = 1'b0;
        err_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (f_req_i || d_req_i) begin
                    capture   = 1'b1;
                    fetch_win = f_req_i && (!d_req_i || (starve_q == STARVE_MAX));
                    // Starvation only accrues while fetch is actually waiting.
                    if (fetch_win || !f_req_i) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + SWIDTH'(1);
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (mem_rvalid_i) begin
                    err_set = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    resp_take = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q     <= '0;
            owner_data_q <= 1'b0;
        end else if (capture) begin
            starve_q     <= starve_d;
            owner_data_q <= !fetch_win;
        end
    end

    // Request payload is frozen at capture so requesters may move on after gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else if (capture) begin
            if (fetch_win) begin
                mem_we_q    <= 1'b0;
                mem_addr_q  <= f_addr_i;
                mem_wdata_q <= '0;
                mem_be_q    <= {BWIDTH{1'b1}};
            end else begin
                mem_we_q    <= d_we_i;
                mem_addr_q  <= d_addr_i;
                mem_wdata_q <= d_wdata_i;
                mem_be_q    <= d_be_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_gnt_q <= 1'b0;
            d_gnt_q <= 1'b0;
        end else begin
            f_gnt_q <= capture && fetch_win;
            d_gnt_q <= capture && !fetch_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            f_rvalid_q <= resp_take && !owner_data_q;
            d_rvalid_q <= resp_take && owner_data_q;
            if (resp_take && !owner_data_q) begin
                f_rdata_q <= mem_rdata_i;
            end
            if (resp_take && owner_data_q) begin
                d_rdata_q <= mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign f_gnt_o     = f_gnt_q;
    assign d_gnt_o     = d_gnt_q;
    assign f_rvalid_o  = f_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign f_rdata_o   = f_rdata_q;
    assign d_rdata_o   = d_rdata_q;

    assign mem_req_o   = (state_q == ST_ISSUE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/load/store paths, priority rotation,
// ready back-pressure, protocol error and mid-transaction reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req_i;
    logic [31:0] f_addr_i;
    logic        f_gnt_o;
    logic        f_rvalid_o;
    logic [31:0] f_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_STARVE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
        .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {60'd0, f_gnt_o, f_rvalid_o, d_gnt_o, d_rvalid_o}, 64'd0);
        chk({tag, "_mem"}, {61'd0, mem_req_o, mem_we_o, |mem_be_o}, 64'd0);
        chk({tag, "_addr_wdata"}, {mem_addr_o, mem_wdata_o}, 64'd0);
        chk({tag, "_rdata"}, {f_rdata_o, d_rdata_o}, 64'd0);
        chk({tag, "_busy_err"}, {62'd0, busy_o, err_o}, 64'd0);
    endtask

    initial begin
        logic exp_data;
        rst_n = 1'b0;
        f_req_i = 1'b0; f_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        step(); step();
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // Single fetch, ready immediately, response k=2 later.
        f_req_i = 1'b1; f_addr_i = 32'h0000_0100; mem_ready_i = 1'b1;
        step();
        chk("f1_gnt", {f_gnt_o, d_gnt_o, mem_req_o}, 3'b101);
        chk("f1_payload", {mem_we_o, mem_be_o, mem_addr_o}, {1'b0, 4'hF, 32'h0000_0100});
        chk("f1_wdata", mem_wdata_o, 32'h0);
        f_req_i = 1'b0;
        step();
        chk("f1_wait", {f_gnt_o, mem_req_o, busy_o}, 3'b001);
        step(); step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        step();
        mem_rvalid_i = 1'b0;
        chk("f1_rvalid", {f_rvalid_o, d_rvalid_o, busy_o}, 3'b100);
        chk("f1_rdata", {f_rdata_o, d_rdata_o}, {32'hDEAD_BEEF, 32'h0});
        step();
        chk("f1_rvalid_pulse", f_rvalid_o, 1'b0);
        chk("f1_rdata_hold", f_rdata_o, 32'hDEAD_BEEF);

        // Store; payload changed right after gnt must not leak to memory.
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_2000;
        d_wdata_i = 32'h1234_5678; d_be_i = 4'b0011;
        step();
        chk("st_gnt", {f_gnt_o, d_gnt_o, mem_req_o}, 3'b011);
        chk("st_payload", {mem_we_o, mem_be_o, mem_addr_o}, {1'b1, 4'b0011, 32'h0000_2000});
        chk("st_wdata", mem_wdata_o, 32'h1234_5678);
        d_req_i = 1'b0; d_wdata_i = 32'hFFFF_FFFF; d_addr_i = 32'h0000_9999;
        step();
        chk("st_wait_payload", {mem_wdata_o, mem_addr_o}, {32'h1234_5678, 32'h0000_2000});
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_5555;
        step();
        mem_rvalid_i = 1'b0;
        chk("st_rvalid", {f_rvalid_o, d_rvalid_o, busy_o}, 3'b010);
        step();
        chk("st_rvalid_pulse", d_rvalid_o, 1'b0);

        // Both requesting continuously: D,D,D,D,F,D,D,D,D,F.
        d_we_i = 1'b0; d_addr_i = 32'h0000_3000; d_be_i = 4'hF; f_addr_i = 32'h0000_0200;
        f_req_i = 1'b1; d_req_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_data = ((i % 5) != 4);
            step();
            chk($sformatf("rot_gnt%0d", i), {f_gnt_o, d_gnt_o}, {!exp_data, exp_data});
            if (i == 9) begin
                f_req_i = 1'b0; d_req_i = 1'b0;
            end
            step();
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000_0000 + 32'(i);
            step();
            mem_rvalid_i = 1'b0;
            chk($sformatf("rot_rv%0d", i), {f_rvalid_o, d_rvalid_o, f_gnt_o, d_gnt_o},
                {!exp_data, exp_data, 2'b00});
        end
        chk("rot_rdata", {f_rdata_o, d_rdata_o}, {32'h1000_0009, 32'h1000_0008});

        // Ready held low for five ISSUE cycles.
        step();
        mem_ready_i = 1'b0;
        d_req_i = 1'b1; d_addr_i = 32'h0000_3004;
        step();
        chk("bp_gnt", {d_gnt_o, mem_req_o}, 2'b11);
        d_req_i = 1'b0; d_addr_i = 32'h0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("bp_hold%0d", j), {d_gnt_o, mem_req_o, mem_addr_o}, {2'b01, 32'h0000_3004});
            if (j == 4) mem_ready_i = 1'b1;
        end
        step();
        chk("bp_wait", {mem_req_o, busy_o, d_gnt_o}, 3'b010);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        step();
        mem_rvalid_i = 1'b0;
        chk("bp_rvalid", {d_rvalid_o, d_rdata_o}, {1'b1, 32'hCAFE_F00D});
        chk("bp_f_hold", f_rdata_o, 32'h1000_0009);

        // mem_rvalid during ISSUE: sticky error, transaction still completes.
        step();
        chk("err_idle", err_o, 1'b0);
        mem_ready_i = 1'b0; d_req_i = 1'b1; d_addr_i = 32'h0000_4000;
        step();
        d_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        step();
        mem_rvalid_i = 1'b0;
        chk("err_set", {err_o, mem_req_o, d_rvalid_o}, 3'b110);
        mem_ready_i = 1'b1;
        step();
        chk("err_wait", {err_o, mem_req_o, busy_o}, 3'b101);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_CAFE;
        step();
        mem_rvalid_i = 1'b0;
        chk("err_done", {err_o, d_rvalid_o, d_rdata_o}, {2'b11, 32'h0BAD_CAFE});
        step(); step();
        chk("err_sticky", err_o, 1'b1);

        // Reset during WAIT; late response in IDLE is dropped.
        f_req_i = 1'b1; f_addr_i = 32'h0000_0400;
        step();
        f_req_i = 1'b0;
        step();
        chk("rst_pre_wait", {busy_o, mem_req_o}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst_async");
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        step();
        mem_rvalid_i = 1'b0;
        chk_outputs_zero("rst_late");
        step();
        chk("rst_late_next", {f_rvalid_o, d_rvalid_o, err_o, busy_o}, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
